// File: rtl/telem_pkg.sv
// rtl/telem_pkg.sv - shared constants, state enum and helpers for the telemetry ADC scanner
package telem_pkg;

    localparam logic [1:0] START_BITS = 2'b11;
    localparam logic [2:0] TAIL_BITS  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } scan_state_t;

    function automatic logic [7:0] ctrl_byte(input logic [2:0] ch);
        return {START_BITS, ch, TAIL_BITS};
    endfunction

    function automatic logic [1:0] range_of(input logic [15:0] value,
                                            input logic [15:0] th0,
                                            input logic [15:0] th1,
                                            input logic [15:0] th2);
        if (value < th0) begin
            return 2'd0;
        end else if (value < th1) begin
            return 2'd1;
        end else if (value < th2) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/telem_adc_scanner_spi_frame_engine.sv
// rtl/telem_adc_scanner_spi_frame_engine.sv - one ADC conversion frame: divider, control byte out, result in
module spi_frame_engine
    import telem_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int CLK_DIV     = 2,
    parameter int FRAME_SCLKS = 24
) (
    input  logic              fab_clk,
    input  logic              fab_resetn,
    input  logic              div_en,
    input  logic              frame_start,
    input  logic [2:0]        frame_ch,
    input  logic              adc_din,
    output logic              tick,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic              adc_dout,
    output logic              frame_done,
    output logic [DATA_W-1:0] frame_data
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGES  = 2 * FRAME_SCLKS;
    localparam int EDGE_W = $clog2(EDGES + 1);

    scan_state_t       st, st_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [6:0]        ctrl_sr;
    logic [DATA_W-1:0] shreg;
    logic [7:0]        cb;
    logic              last_edge;
    logic              capture;
    int                rise_idx;

    assign tick      = div_en && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign cb        = ctrl_byte(frame_ch);
    assign last_edge = (edge_cnt == EDGE_W'(EDGES - 1));
    assign rise_idx  = int'(edge_cnt[EDGE_W-1:1]);
    // rising edges 0..7 clock the control byte, 8 is the ADC busy clock
    assign capture   = !adc_sclk && (rise_idx >= 9) && (rise_idx <= 8 + DATA_W);

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:  if (frame_start) st_nxt = ST_SETUP;
            ST_SETUP: if (tick) st_nxt = ST_SHIFT;
            ST_SHIFT: if (tick && last_edge) st_nxt = ST_IDLE;
            default:  st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge fab_clk or negedge fab_resetn) begin
        if (!fab_resetn) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_ff @(posedge fab_clk or negedge fab_resetn) begin
        if (!fab_resetn) begin
            div_cnt    <= '0;
            edge_cnt   <= '0;
            ctrl_sr    <= '0;
            shreg      <= '0;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b0;
            adc_dout   <= 1'b0;
            frame_done <= 1'b0;
            frame_data <= '0;
        end else begin
            frame_done <= 1'b0;
            // restarting on frame_start keeps SETUP exactly one tick long
            if (!div_en || frame_start || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (st == ST_IDLE && frame_start) begin
                adc_cs_n <= 1'b0;
                adc_dout <= cb[7];
                ctrl_sr  <= cb[6:0];
                edge_cnt <= '0;
                shreg    <= '0;
            end else if (st == ST_SHIFT && tick) begin
                adc_sclk <= ~adc_sclk;
                edge_cnt <= edge_cnt + 1'b1;
                if (capture) begin
                    shreg <= {shreg[DATA_W-2:0], adc_din};
                end
                if (adc_sclk) begin
                    adc_dout <= ctrl_sr[6];
                    ctrl_sr  <= {ctrl_sr[5:0], 1'b0};
                end
                if (last_edge) begin
                    adc_cs_n   <= 1'b1;
                    adc_dout   <= 1'b0;
                    frame_done <= 1'b1;
                    frame_data <= shreg;
                end
            end
        end
    end

endmodule

// File: rtl/telem_adc_scanner.sv
// rtl/telem_adc_scanner.sv - multi-channel telemetry ADC sequencer with result bank and range classifier
module telem_adc_scanner
    import telem_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int DATA_W      = 12,
    parameter int CLK_DIV     = 2,
    parameter int FRAME_SCLKS = 24,
    parameter int CS_GAP      = 4,
    parameter int CLS_CH      = 2,
    parameter int TH0         = 500,
    parameter int TH1         = 1500,
    parameter int TH2         = 2500
) (
    input  logic              fab_clk,
    input  logic              fab_resetn,
    input  logic              start,
    input  logic              cont,
    input  logic [N_CH-1:0]   ch_mask,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic              adc_dout,
    input  logic              adc_din,
    output logic              busy,
    output logic              smp_valid,
    output logic [2:0]        smp_ch,
    output logic [DATA_W-1:0] smp_data,
    output logic              scan_done,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        range_code
);

    localparam int GAP_TICKS = 2 * CS_GAP;
    localparam int GAP_W     = $clog2(GAP_TICKS + 1);

    scan_state_t       state, state_nxt;
    logic [N_CH-1:0]   mask_q;
    logic [2:0]        cur_ch;
    logic [2:0]        frame_ch;
    logic [2:0]        next_ch;
    logic [2:0]        first_ch;
    logic              has_next;
    logic              has_first;
    logic [GAP_W-1:0]  gap_cnt;
    logic              tick;
    logic              frame_start;
    logic              frame_done;
    logic [DATA_W-1:0] frame_data;
    logic              gap_end;
    logic              accept;
    logic              rescan;
    logic [DATA_W-1:0] bank [N_CH];

    spi_frame_engine #(
        .DATA_W      (DATA_W),
        .CLK_DIV     (CLK_DIV),
        .FRAME_SCLKS (FRAME_SCLKS)
    ) u_engine (
        .fab_clk     (fab_clk),
        .fab_resetn  (fab_resetn),
        .div_en      (state != ST_IDLE),
        .frame_start (frame_start),
        .frame_ch    (frame_ch),
        .adc_din     (adc_din),
        .tick        (tick),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_dout    (adc_dout),
        .frame_done  (frame_done),
        .frame_data  (frame_data)
    );

    // descending loops leave the lowest qualifying index as the winner
    always_comb begin
        has_first = 1'b0;
        first_ch  = 3'd0;
        has_next  = 1'b0;
        next_ch   = 3'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                has_first = 1'b1;
                first_ch  = 3'(i);
            end
            if (mask_q[i] && (i > int'(cur_ch))) begin
                has_next = 1'b1;
                next_ch  = 3'(i);
            end
        end
    end

    assign accept  = (state == ST_IDLE) && start && !scan_done && has_first;
    assign gap_end = (state == ST_GAP) && tick && (gap_cnt == GAP_W'(GAP_TICKS - 1));
    assign rescan  = cont && has_first;

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_ch    = cur_ch;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                frame_start = 1'b1;
                state_nxt   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (frame_done) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_end) begin
                    if (has_next) begin
                        frame_start = 1'b1;
                        frame_ch    = next_ch;
                        state_nxt   = ST_SHIFT;
                    end else if (rescan) begin
                        frame_start = 1'b1;
                        frame_ch    = first_ch;
                        state_nxt   = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge fab_clk or negedge fab_resetn) begin
        if (!fab_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge fab_clk or negedge fab_resetn) begin
        if (!fab_resetn) begin
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            mask_q     <= '0;
            cur_ch     <= 3'd0;
            gap_cnt    <= '0;
            range_code <= 2'd0;
            for (int i = 0; i < N_CH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            scan_done <= 1'b0;
            if (accept) begin
                mask_q <= ch_mask;
                cur_ch <= first_ch;
                busy   <= 1'b1;
            end
            if (frame_done) begin
                gap_cnt <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    if (cur_ch == 3'(i)) bank[i] <= frame_data;
                end
                if (cur_ch == 3'(CLS_CH)) begin
                    range_code <= range_of(16'(frame_data), 16'(TH0), 16'(TH1), 16'(TH2));
                end
            end else if (state == ST_GAP && tick) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (gap_end) begin
                if (has_next) begin
                    cur_ch <= next_ch;
                end else begin
                    scan_done <= 1'b1;
                    if (rescan) begin
                        mask_q <= ch_mask;
                        cur_ch <= first_ch;
                    end else begin
                        busy <= 1'b0;
                    end
                end
            end
        end
    end

    assign smp_valid = frame_done;
    assign smp_ch    = cur_ch;
    assign smp_data  = frame_data;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_addr == 3'(i)) rd_data = bank[i];
        end
    end

endmodule

// File: tb/tb_telem_adc_scanner.sv
// tb/tb_telem_adc_scanner.sv - scoreboard bench for telem_adc_scanner (default build and CLK_DIV=1/DATA_W=10 build)
module tb_telem_adc_scanner;

    localparam int DW_A = 12;
    localparam int DW_B = 10;

    logic fab_clk = 1'b0;
    always #5 fab_clk = ~fab_clk;

    logic            fab_resetn;
    logic            start, cont;
    logic [7:0]      ch_mask;
    logic [2:0]      rd_addr;
    logic            cs_n_a, sclk_a, dout_a, busy_a, smp_valid_a, scan_done_a;
    logic            din_a = 1'b0;
    logic [2:0]      smp_ch_a;
    logic [DW_A-1:0] smp_data_a, rd_data_a;
    logic [1:0]      range_a;

    logic            start_b;
    logic [7:0]      ch_mask_b;
    logic [2:0]      rd_addr_b;
    logic            cs_n_b, sclk_b, dout_b, busy_b, smp_valid_b, scan_done_b;
    logic            din_b = 1'b0;
    logic [2:0]      smp_ch_b;
    logic [DW_B-1:0] smp_data_b, rd_data_b;
    logic [1:0]      range_b;

    telem_adc_scanner u_dut_a (
        .fab_clk(fab_clk), .fab_resetn(fab_resetn), .start(start), .cont(cont), .ch_mask(ch_mask),
        .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .adc_dout(dout_a), .adc_din(din_a), .busy(busy_a),
        .smp_valid(smp_valid_a), .smp_ch(smp_ch_a), .smp_data(smp_data_a), .scan_done(scan_done_a),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .range_code(range_a)
    );

    telem_adc_scanner #(.DATA_W(DW_B), .CLK_DIV(1)) u_dut_b (
        .fab_clk(fab_clk), .fab_resetn(fab_resetn), .start(start_b), .cont(1'b0), .ch_mask(ch_mask_b),
        .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_dout(dout_b), .adc_din(din_b), .busy(busy_b),
        .smp_valid(smp_valid_b), .smp_ch(smp_ch_b), .smp_data(smp_data_b), .scan_done(scan_done_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .range_code(range_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_qb[$];
    logic [15:0] adc_val   [8];
    logic [15:0] adc_val_b [8];

    // ADC models: latch control byte on sclk rises, drive result MSB first after falling edge 8
    int         frm_a = 0, rfrm_a = 0, ffrm_a = 0, redge_a = 0, fedge_a = 0;
    logic [7:0]  cap_a = 8'h00;
    logic [15:0] sh_a  = 16'h0;
    always @(negedge cs_n_a) frm_a++;
    always @(posedge sclk_a) begin
        if (rfrm_a != frm_a) begin rfrm_a = frm_a; redge_a = 0; end
        if (redge_a < 8) cap_a = {cap_a[6:0], dout_a};
        redge_a++;
    end
    always @(negedge sclk_a) begin
        if (ffrm_a != frm_a) begin ffrm_a = frm_a; fedge_a = 0; end
        if (fedge_a == 8) sh_a = adc_val[cap_a[5:3]];
        if (fedge_a >= 8 && fedge_a < 8 + DW_A) din_a = sh_a[DW_A-1-(fedge_a-8)];
        else din_a = 1'b0;
        fedge_a++;
    end

    int         frm_b = 0, rfrm_b = 0, ffrm_b = 0, redge_b = 0, fedge_b = 0;
    logic [7:0]  cap_b = 8'h00;
    logic [15:0] sh_b  = 16'h0;
    always @(negedge cs_n_b) frm_b++;
    always @(posedge sclk_b) begin
        if (rfrm_b != frm_b) begin rfrm_b = frm_b; redge_b = 0; end
        if (redge_b < 8) cap_b = {cap_b[6:0], dout_b};
        redge_b++;
    end
    always @(negedge sclk_b) begin
        if (ffrm_b != frm_b) begin ffrm_b = frm_b; fedge_b = 0; end
        if (fedge_b == 8) sh_b = adc_val_b[cap_b[5:3]];
        if (fedge_b >= 8 && fedge_b < 8 + DW_B) din_b = sh_b[DW_B-1-(fedge_b-8)];
        else din_b = 1'b0;
        fedge_b++;
    end

    int   frames_a = 0, dones_a = 0, lowcnt_a = 0, hicnt_a = 0, last_gap_a = 0;
    logic cs_prev_a = 1'b1;
    always @(negedge fab_clk) begin
        exp_t e;
        if (!fab_resetn) begin
            lowcnt_a = 0;
            hicnt_a  = 0;
        end else begin
            if (!cs_n_a) begin
                if (cs_prev_a) begin
                    frames_a++;
                    if (hicnt_a > 1) last_gap_a = hicnt_a;
                    hicnt_a = 0;
                end
                lowcnt_a++;
            end else begin
                if (lowcnt_a != 0) chk("cs_low_len_a", lowcnt_a, 98);
                lowcnt_a = 0;
                if (busy_a) hicnt_a++;
            end
            if (smp_valid_a) begin
                if (exp_q.size() == 0) begin
                    chk("smp_valid_unexpected_a", {31'd0, smp_valid_a}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("smp_ch_a", {29'd0, smp_ch_a}, {29'd0, e.ch});
                    chk("smp_data_a", {20'd0, smp_data_a}, {16'd0, e.data});
                    chk("ctrl_byte_a", {24'd0, cap_a}, {24'd0, 2'b11, e.ch, 3'b111});
                end
            end
            if (scan_done_a) dones_a++;
        end
        cs_prev_a = cs_n_a;
    end

    int   lowcnt_b = 0, cyc_b = 0, last_rise_b = 0;
    logic sclk_prev_b = 1'b0;
    always @(negedge fab_clk) begin
        exp_t e;
        cyc_b++;
        if (fab_resetn) begin
            if (!cs_n_b) begin
                lowcnt_b++;
                if (sclk_b && !sclk_prev_b) begin
                    if (last_rise_b != 0) chk("sclk_period_b", cyc_b - last_rise_b, 2);
                    last_rise_b = cyc_b;
                end
            end else begin
                if (lowcnt_b != 0) chk("cs_low_len_b", lowcnt_b, 49);
                lowcnt_b    = 0;
                last_rise_b = 0;
            end
            if (smp_valid_b) begin
                if (exp_qb.size() == 0) begin
                    chk("smp_valid_unexpected_b", {31'd0, smp_valid_b}, 0);
                end else begin
                    e = exp_qb.pop_front();
                    chk("smp_ch_b", {29'd0, smp_ch_b}, {29'd0, e.ch});
                    chk("smp_data_b", {22'd0, smp_data_b}, {16'd0, e.data});
                    chk("ctrl_byte_b", {24'd0, cap_b}, {24'd0, 2'b11, e.ch, 3'b111});
                end
            end
        end
        sclk_prev_b = sclk_b;
    end

    task automatic pulse_a();
        @(negedge fab_clk) start = 1'b1;
        @(negedge fab_clk) start = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget);
        int n = 0;
        while (busy_a && n < budget) begin @(negedge fab_clk); n++; end
        if (busy_a) chk("timeout_idle_a", {31'd0, busy_a}, 0);
    endtask

    task automatic push_a(input logic [2:0] ch, input logic [15:0] v);
        exp_t e;
        e.ch = ch; e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic rd_chk_a(input logic [2:0] a, input logic [15:0] v, input string nm);
        rd_addr = a;
        #1 chk(nm, {20'd0, rd_data_a}, {16'd0, v});
    endtask

    int sweep_v [6] = '{499, 500, 1500, 2499, 2500, 4095};
    int sweep_c [6] = '{0, 1, 2, 2, 3, 3};

    initial begin
        int d0, f0, n;
        exp_t eb;
        fab_resetn = 1'b0; start = 1'b0; cont = 1'b0; ch_mask = 8'h00; rd_addr = 3'd0;
        start_b = 1'b0; ch_mask_b = 8'h00; rd_addr_b = 3'd0;
        for (int i = 0; i < 8; i++) begin adc_val[i] = 16'h0; adc_val_b[i] = 16'h0; end
        repeat (3) @(negedge fab_clk);
        chk("rst_cs_n", {31'd0, cs_n_a}, 1);
        chk("rst_sclk", {31'd0, sclk_a}, 0);
        chk("rst_dout", {31'd0, dout_a}, 0);
        chk("rst_busy", {31'd0, busy_a}, 0);
        chk("rst_smp_valid", {31'd0, smp_valid_a}, 0);
        chk("rst_smp_ch", {29'd0, smp_ch_a}, 0);
        chk("rst_smp_data", {20'd0, smp_data_a}, 0);
        chk("rst_scan_done", {31'd0, scan_done_a}, 0);
        chk("rst_range", {30'd0, range_a}, 0);
        for (int i = 0; i < 8; i++) rd_chk_a(3'(i), 16'h0, "rst_bank");
        @(negedge fab_clk) fab_resetn = 1'b1;

        // reset in the middle of a frame
        ch_mask = 8'h01; adc_val[0] = 16'h555;
        pulse_a();
        n = 0;
        while (cs_n_a && n < 100) begin @(negedge fab_clk); n++; end
        chk("abort_frame_started", {31'd0, cs_n_a}, 0);
        repeat (40) @(negedge fab_clk);
        fab_resetn = 1'b0;
        #1;
        chk("abort_cs_n", {31'd0, cs_n_a}, 1);
        chk("abort_sclk", {31'd0, sclk_a}, 0);
        repeat (2) @(negedge fab_clk);
        fab_resetn = 1'b1;
        repeat (200) @(negedge fab_clk);
        chk("abort_busy", {31'd0, busy_a}, 0);
        rd_chk_a(3'd0, 16'h0, "abort_bank0");

        // two-channel single scan
        adc_val[0] = 16'h1F4; adc_val[2] = 16'hABC; ch_mask = 8'h05;
        push_a(3'd0, 16'h1F4); push_a(3'd2, 16'hABC);
        d0 = dones_a; f0 = frames_a;
        pulse_a();
        wait_idle_a(2000);
        repeat (2) @(negedge fab_clk);
        chk("scan2_done_cnt", dones_a - d0, 1);
        chk("scan2_frames", frames_a - f0, 2);
        rd_chk_a(3'd2, 16'hABC, "scan2_bank2");
        rd_chk_a(3'd0, 16'h1F4, "scan2_bank0");
        chk("scan2_range", {30'd0, range_a}, 3);
        chk("scan2_sb_empty", exp_q.size(), 0);

        // classification sweep on channel 2
        ch_mask = 8'h04;
        for (int i = 0; i < 6; i++) begin
            adc_val[2] = 16'(sweep_v[i]);
            push_a(3'd2, 16'(sweep_v[i]));
            pulse_a();
            wait_idle_a(2000);
            repeat (2) @(negedge fab_clk);
            chk("sweep_range", {30'd0, range_a}, sweep_c[i]);
        end

        // classifier channel not enabled: code holds
        ch_mask = 8'h01; adc_val[0] = 16'h010;
        push_a(3'd0, 16'h010);
        pulse_a();
        wait_idle_a(2000);
        repeat (2) @(negedge fab_clk);
        chk("nocls_range", {30'd0, range_a}, 3);
        rd_chk_a(3'd0, 16'h010, "nocls_bank0");
        rd_chk_a(3'd2, 16'hFFF, "nocls_bank2");

        // start with empty mask is ignored
        ch_mask = 8'h00; d0 = dones_a; f0 = frames_a;
        pulse_a();
        repeat (300) @(negedge fab_clk);
        chk("empty_busy", {31'd0, busy_a}, 0);
        chk("empty_frames", frames_a - f0, 0);
        chk("empty_done", dones_a - d0, 0);

        // second start while busy, mask changed mid-scan
        ch_mask = 8'h02; adc_val[1] = 16'h123; d0 = dones_a; f0 = frames_a;
        push_a(3'd1, 16'h123);
        pulse_a();
        repeat (50) @(negedge fab_clk);
        ch_mask = 8'hFF;
        pulse_a();
        wait_idle_a(2000);
        repeat (2) @(negedge fab_clk);
        chk("busy_start_frames", frames_a - f0, 1);
        chk("busy_start_done", dones_a - d0, 1);
        rd_chk_a(3'd1, 16'h123, "busy_start_bank1");
        chk("busy_start_sb_empty", exp_q.size(), 0);

        // continuous mode on ch7, cont dropped during the third frame
        ch_mask = 8'h80; adc_val[7] = 16'h7E5; cont = 1'b1; d0 = dones_a; f0 = frames_a;
        for (int i = 0; i < 3; i++) push_a(3'd7, 16'h7E5);
        pulse_a();
        n = 0;
        while (frames_a < f0 + 3 && n < 2000) begin @(negedge fab_clk); n++; end
        chk("cont_third_frame", {31'd0, frames_a >= f0 + 3}, 1);
        repeat (20) @(negedge fab_clk);
        cont = 1'b0;
        wait_idle_a(2000);
        repeat (2) @(negedge fab_clk);
        chk("cont_frames", frames_a - f0, 3);
        chk("cont_done", dones_a - d0, 3);
        chk("cont_gap_len", last_gap_a, 16);
        chk("cont_sb_empty", exp_q.size(), 0);
        rd_chk_a(3'd7, 16'h7E5, "cont_bank7");

        // CLK_DIV=1, DATA_W=10 build
        ch_mask_b = 8'h02; adc_val_b[1] = 16'h2A5;
        eb.ch = 3'd1; eb.data = 16'h2A5;
        exp_qb.push_back(eb);
        @(negedge fab_clk) start_b = 1'b1;
        @(negedge fab_clk) start_b = 1'b0;
        n = 0;
        while (busy_b && n < 1000) begin @(negedge fab_clk); n++; end
        chk("b_idle", {31'd0, busy_b}, 0);
        repeat (2) @(negedge fab_clk);
        rd_addr_b = 3'd1;
        #1 chk("b_bank1", {22'd0, rd_data_b}, 32'h2A5);
        chk("b_sb_empty", exp_qb.size(), 0);
        chk("b_range", {30'd0, range_b}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
